bit_serializer: RTL

Parallel-to-serial stage feeding the 1011 sequence detector's `data_in`. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. Consecutive words are emitted with no gap cycles, so patterns that span a word boundary reach the detector intact. When no word is active, the serial line drives a constant idle level.

---
 rtl/bit_serializer_if.sv | 23 ++
 rtl/bit_serializer.sv | 72 +++++++
 2 files changed

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle for the bit serializer.
// master = upstream word source plus serial-line observer, slave = the serializer.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             data_out;
  logic             out_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, data_out, out_valid, word_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, data_out, out_valid, word_done, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: WIDTH-bit words in over valid/ready, one bit per clock out,
// with back-to-back words emitted gaplessly.
//
// state | meaning
// IDLE  | no word held, serial line at IDLE_BIT
// SHIFT | word in flight, cnt = bits still to emit after the current one
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  bit_serializer_if.slave     bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             data_out_q;
  logic             out_valid_q;
  logic             word_done_q;
  logic             busy_q;
  logic             in_ready_c;
  logic             accept;

  assign in_ready_c = !reset && ((state == IDLE) || ((state == SHIFT) && (cnt == '0)));
  assign accept     = bus.in_valid && in_ready_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.word_done = word_done_q;
  assign bus.busy      = busy_q;

  // The first bit goes straight from in_data to the output; shreg keeps the
  // remaining bits pre-shifted so its edge bit is always the next to send.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      data_out_q  <= IDLE_BIT;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // WIDTH >= 2, so a freshly loaded word never starts on its last bit
      word_done_q <= (state == SHIFT) && (cnt == CW'(1));
      if (accept) begin
        state       <= SHIFT;
        cnt         <= CW'(WIDTH - 1);
        data_out_q  <= MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
        shreg       <= MSB_FIRST ? (bus.in_data << 1) : (bus.in_data >> 1);
        out_valid_q <= 1'b1;
        busy_q      <= 1'b1;
      end else if (state == SHIFT && cnt != '0) begin
        cnt        <= cnt - CW'(1);
        data_out_q <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        shreg      <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      end else if (state == SHIFT) begin
        state       <= IDLE;
        data_out_q  <= IDLE_BIT;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end
    end
  end
endmodule
